// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by an external oversampling tick; samples each bit at
// its midpoint and reports the byte with a one-cycle done strobe and a framing flag.
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned STOP_WIDTH = 16,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_ticks,
    input  logic                  i_rx,
    output logic [DATA_WIDTH-1:0] o_data_byte,
    output logic                  o_rx_done,
    output logic                  o_frame_err
);

    localparam int unsigned S_SPAN = (OVERSAMPLE > STOP_WIDTH) ? OVERSAMPLE : STOP_WIDTH;
    localparam int unsigned SW     = (S_SPAN > 1) ? $clog2(S_SPAN) : 1;
    localparam int unsigned NW     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(STOP_WIDTH - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state;
    logic [SW-1:0]         s;
    logic [NW-1:0]         n;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  rx_meta;
    logic                  rx_s;

    // Two-flop synchroniser for the asynchronous line, idle-high out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM; STOP returns to IDLE at the stop-bit midpoint so a start edge
    // immediately following the stop bit is still caught.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            s           <= '0;
            n           <= '0;
            shreg       <= '0;
            o_data_byte <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_rx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (i_ticks) begin
                        if (s == S_MID) begin
                            s <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (i_ticks) begin
                        if (s == S_BIT) begin
                            s     <= '0;
                            shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
                            if (n == N_LAST) begin
                                state <= STOP;
                            end else begin
                                n <= n + NW'(1);
                            end
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (i_ticks) begin
                        if (s == S_STOP) begin
                            s           <= '0;
                            state       <= IDLE;
                            o_data_byte <= shreg;
                            o_frame_err <= ~rx_s;
                            o_rx_done   <= 1'b1;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    s     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus randomized frames, checked against a
// frame-level model (byte = data bits sent, error = stop bit driven low).
module tb_uart_rx;

    localparam int TICK_DIV = 4;
    localparam int OS       = 16;
    localparam int BIT_CLKS = OS * TICK_DIV;
    localparam int N_RAND   = 24;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_ticks = 1'b0;
    logic       i_rx = 1'b1;
    logic [7:0] o_data_byte;
    logic       o_rx_done;
    logic       o_frame_err;

    int     checks = 0;
    int     failures = 0;
    bit     tick_en = 1'b1;
    int     tick_cnt = 0;
    longint cyc = 0;
    int     wide_cnt = 0;
    logic   prev_done = 1'b0;
    int     bad = 0;

    logic [7:0] got_d[$];
    bit         got_e[$];
    longint     got_c[$];
    logic [7:0] exp_d[$];
    bit         exp_e[$];
    longint     exp_c[$];
    logic [7:0] last_d = 8'h00;
    bit         last_e = 1'b0;

    logic [7:0] rnd_d;
    bit         rnd_good;
    int         rnd_gap;
    logic [7:0] abort_byte;

    uart_rx dut (
        .clk        (clk),
        .reset      (reset),
        .i_ticks    (i_ticks),
        .i_rx       (i_rx),
        .o_data_byte(o_data_byte),
        .o_rx_done  (o_rx_done),
        .o_frame_err(o_frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Oversampling tick: one clk wide every TICK_DIV clocks.
    initial begin
        forever begin
            @(negedge clk);
            i_ticks = tick_en && (tick_cnt == TICK_DIV - 1);
            tick_cnt = (tick_cnt + 1) % TICK_DIV;
        end
    end

    // Collect every done pulse and flag any pulse wider than one clock.
    always @(negedge clk) begin
        if (o_rx_done === 1'b1) begin
            got_d.push_back(o_data_byte);
            got_e.push_back(o_frame_err);
            got_c.push_back(cyc);
            if (prev_done === 1'b1) wide_cnt++;
        end
        prev_done = o_rx_done;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit good, input int gap);
        exp_d.push_back(d);
        exp_e.push_back(!good);
        exp_c.push_back(cyc);
        i_rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        if (good) begin
            i_rx = 1'b1;
            repeat (BIT_CLKS) @(negedge clk);
        end else begin
            // Low stop covers the sample point, then releases so no false start follows.
            i_rx = 1'b0;
            repeat (12 * TICK_DIV) @(negedge clk);
            i_rx = 1'b1;
            repeat (BIT_CLKS) @(negedge clk);
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_frames(input string tag);
        int b;
        b = 0;
        while (got_d.size() < exp_d.size() && b < 6 * BIT_CLKS) begin
            @(negedge clk);
            b++;
        end
        check({tag, "_wait"}, 32'(got_d.size() >= exp_d.size()), 32'd1);
    endtask

    task automatic compare_frames(input string tag);
        logic [7:0] gd;
        logic [7:0] ed;
        bit         ge;
        bit         ee;
        longint     gc;
        longint     ec;
        check({tag, "_count"}, 32'(got_d.size()), 32'(exp_d.size()));
        while (exp_d.size() > 0 && got_d.size() > 0) begin
            gd = got_d.pop_front();
            ge = got_e.pop_front();
            gc = got_c.pop_front();
            ed = exp_d.pop_front();
            ee = exp_e.pop_front();
            ec = exp_c.pop_front();
            check({tag, "_data"}, 32'(gd), 32'(ed));
            check({tag, "_err"}, 32'(ge), 32'(ee));
            check({tag, "_latency"}, 32'((gc - ec) <= longint'(10 * BIT_CLKS)), 32'd1);
            last_d = ed;
            last_e = ee;
        end
        got_d.delete();
        got_e.delete();
        got_c.delete();
        exp_d.delete();
        exp_e.delete();
        exp_c.delete();
        check({tag, "_hold_data"}, 32'(o_data_byte), 32'(last_d));
        check({tag, "_hold_err"}, 32'(o_frame_err), 32'(last_e));
    endtask

    initial begin
        reset = 1'b1;
        i_rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(o_data_byte), 32'h0);
        check("rst_done", 32'(o_rx_done), 32'h0);
        check("rst_err", 32'(o_frame_err), 32'h0);
        reset = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);

        send_frame(8'h2F, 1'b1, BIT_CLKS);
        wait_frames("loop");
        compare_frames("loop");

        // Short low pulse must be rejected as a glitch.
        i_rx = 1'b0;
        repeat (4 * TICK_DIV) @(negedge clk);
        i_rx = 1'b1;
        repeat (12 * BIT_CLKS) @(negedge clk);
        check("glitch_no_done", 32'(got_d.size()), 32'd0);
        check("glitch_data", 32'(o_data_byte), 32'(last_d));

        send_frame(8'hA5, 1'b0, BIT_CLKS);
        send_frame(8'h3C, 1'b1, BIT_CLKS);
        wait_frames("ferr");
        compare_frames("ferr");

        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, BIT_CLKS);
        wait_frames("b2b");
        compare_frames("b2b");

        // Abort a frame with a one-clock reset after the third data bit.
        abort_byte = 8'h92;
        i_rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            i_rx = abort_byte[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        reset = 1'b1;
        i_rx  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_data", 32'(o_data_byte), 32'h0);
        check("mrst_done", 32'(o_rx_done), 32'h0);
        check("mrst_err", 32'(o_frame_err), 32'h0);
        last_d = 8'h00;
        last_e = 1'b0;
        repeat (12 * BIT_CLKS) @(negedge clk);
        check("mrst_no_done", 32'(got_d.size()), 32'd0);
        send_frame(8'h55, 1'b1, BIT_CLKS);
        wait_frames("mrst");
        compare_frames("mrst");

        tick_en = 1'b0;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (o_rx_done !== 1'b0 || o_data_byte !== last_d || o_frame_err !== last_e) bad++;
        end
        check("noticks_static", 32'(bad), 32'd0);
        check("noticks_no_done", 32'(got_d.size()), 32'd0);
        tick_en = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);

        for (int k = 0; k < N_RAND; k++) begin
            rnd_d    = 8'($urandom);
            rnd_good = ($urandom_range(0, 3) != 0);
            rnd_gap  = int'($urandom_range(0, 2 * BIT_CLKS));
            send_frame(rnd_d, rnd_good, rnd_gap);
        end
        wait_frames("rand");
        compare_frames("rand");

        check("done_width", 32'(wide_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
